// File: rtl/ram_io_responder_pkg.sv
// ram_io_responder_pkg: shared IO map constants, bus encodings and IO address decode
package ram_io_responder_pkg;
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
  localparam logic [3:0] IO_TX_OFF = 4'h0;
  localparam logic [3:0] IO_HALT_OFF = 4'h4;
  localparam logic RAM_TYPE_LOAD = 1'b0;
  localparam logic RAM_TYPE_STORE = 1'b1;
  typedef enum logic [1:0] {IO_NONE, IO_TX, IO_HALT, IO_OTHER} io_kind_e;
  function automatic io_kind_e io_decode(input logic [15:0] addr_hi, input logic [3:0] off, input logic [15:0] base_hi);
    return addr_hi != base_hi ? IO_NONE : off == IO_TX_OFF ? IO_TX : off == IO_HALT_OFF ? IO_HALT : IO_OTHER;
  endfunction
endpackage

// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if: byte-serial memory bus between controller (master) and responder (slave)
//   ram_type       1 store / 0 load
//   addr_ram       byte address
//   data_ram       store data
//   data_ram_in    load data, one cycle after the address
//   io_buffer_full TX FIFO near-full flow control
interface ram_io_responder_if;
  logic ram_type;
  logic [31:0] addr_ram;
  logic [7:0] data_ram;
  logic [7:0] data_ram_in;
  logic io_buffer_full;
  modport master(output ram_type, addr_ram, data_ram, input data_ram_in, io_buffer_full);
  modport slave(input ram_type, addr_ram, data_ram, output data_ram_in, io_buffer_full);
endinterface

// File: rtl/ram_io_responder_io_tx_fifo.sv
// io_tx_fifo: byte FIFO feeding the host TX stream
//   push_i/din_i/full_o  write side; a push on full is accepted only alongside a pop
//   pop_i/dout_o/empty_o read side; dout_o is the head entry (0 when empty)
//   count_o              current occupancy
module io_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] count_q, count_d;
  logic rd, wr;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign rd = pop_i && !empty_o;
  assign wr = push_i && (!full_o || rd);
  assign count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
  assign count_o = count_q;
  assign dout_o = empty_o ? 8'h00 : mem_q[rd_q];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_q + AW'(rd);
      wr_q <= wr_q + AW'(wr);
      count_q <= count_d;
    end
  always_ff @(posedge clk_i)
    if (wr) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-serial memory bus responder with RAM and memory-mapped IO window
//   clk_in/rst_in  clock, asynchronous active-high reset
//   rdy_in         global enable; low freezes all state
//   bus            slave side of the controller memory bus
//   tx_*           TX byte stream toward the host
//   io_overflow    sticky: IO store dropped on full FIFO
//   sim_halt       sticky: store to IO_BASE+4 seen
//   rx_*           host input byte port, only with IO_RX_EN defined
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH = 8,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  ram_io_responder_if.slave bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       io_overflow,
  output logic       sim_halt,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_pop
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  io_kind_e kind;
  logic is_store, is_load, pop_fire, push_req, push_ok, fifo_full, fifo_empty;
  logic [CW-1:0] count, count_nx;
  logic [7:0] ram_rd_q, io_val_q, io_val_d, rx_val;
  logic io_sel_q, io_sel_d, full_q, full_d, ovf_q, ovf_d, halt_q, halt_d, rx_pop_q, rx_pop_d;
  assign idx = bus.addr_ram[ADDR_WIDTH-1:0];
  assign kind = io_decode(bus.addr_ram[31:16], bus.addr_ram[3:0], IO_BASE[31:16]);
  assign is_store = bus.ram_type == RAM_TYPE_STORE;
  assign is_load = bus.ram_type == RAM_TYPE_LOAD;
  assign tx_valid = !fifo_empty;
  assign pop_fire = rdy_in && tx_valid && tx_ready;
  assign push_req = rdy_in && is_store && kind == IO_TX;
  assign push_ok = push_req && (!fifo_full || pop_fire);
  assign count_nx = count + CW'(push_ok) - CW'(pop_fire);
`ifdef IO_RX_EN
  assign rx_val = rx_valid ? rx_data : 8'h00;
  assign rx_pop_d = rdy_in && is_load && kind == IO_TX && rx_valid;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid};
  assign rx_val = 8'h00;
  assign rx_pop_d = 1'b0;
`endif
  // Flag tracks the post-edge occupancy so it never lags the FIFO count
  always_comb begin
    io_sel_d = kind != IO_NONE;
    io_val_d = is_load && kind == IO_TX ? rx_val : 8'h00;
    full_d = count_nx >= CW'(TX_DEPTH - 2);
    ovf_d = ovf_q || (push_req && !push_ok);
    halt_d = halt_q || (is_store && kind == IO_HALT);
  end
  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk_i(clk_in),
    .rst_i(rst_in),
    .push_i(push_req),
    .din_i(bus.data_ram),
    .full_o(fifo_full),
    .pop_i(pop_fire),
    .dout_o(tx_data),
    .empty_o(fifo_empty),
    .count_o(count)
  );
  // RAM is never reset; read-before-write on the same index
  always_ff @(posedge clk_in)
    if (rdy_in) begin
      if (is_store && kind == IO_NONE) mem[idx] <= bus.data_ram;
      ram_rd_q <= mem[idx];
    end
  // io_sel_q resets high with io_val_q=0 so data_ram_in reads 0 out of reset
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      io_sel_q <= 1'b1;
      io_val_q <= 8'h00;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      halt_q <= 1'b0;
      rx_pop_q <= 1'b0;
    end else begin
      rx_pop_q <= rx_pop_d;
      if (rdy_in) begin
        io_sel_q <= io_sel_d;
        io_val_q <= io_val_d;
        full_q <= full_d;
        ovf_q <= ovf_d;
        halt_q <= halt_d;
      end
    end
  assign bus.data_ram_in = io_sel_q ? io_val_q : ram_rd_q;
  assign bus.io_buffer_full = full_q;
  assign io_overflow = ovf_q;
  assign sim_halt = halt_q;
  assign rx_pop = rx_pop_q;
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed self-checking bench for ram_io_responder
module tb_ram_io_responder;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00, tx_data;
  logic tx_valid, io_overflow, sim_halt, rx_pop;
  int n_chk = 0, n_fail = 0;
  logic [7:0] drain [8];
  logic [7:0] rx_exp;
  ram_io_responder_if bus();
  ram_io_responder dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .io_overflow(io_overflow), .sim_halt(sim_halt),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.ram_type = 1'b0;
    bus.addr_ram = 32'hffff_ffff;
    bus.data_ram = 8'h00;
  endtask
  task automatic st(input logic [31:0] a, input logic [7:0] d);
    bus.ram_type = 1'b1;
    bus.addr_ram = a;
    bus.data_ram = d;
    tick();
    idle();
  endtask
  task automatic ld(input logic [31:0] a);
    bus.ram_type = 1'b0;
    bus.addr_ram = a;
    tick();
    idle();
  endtask
  initial begin
    idle();
    repeat (3) tick();
    check("rst_data_ram_in", bus.data_ram_in, 8'h00);
    check("rst_buf_full", bus.io_buffer_full, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_overflow", io_overflow, 0);
    check("rst_halt", sim_halt, 0);
    check("rst_rx_pop", rx_pop, 0);
    rst = 1'b0;
    tick();
    st(32'h100, 8'h11); st(32'h101, 8'h22); st(32'h102, 8'h33); st(32'h103, 8'h44);
    ld(32'h100); check("ld_100", bus.data_ram_in, 8'h11);
    ld(32'h101); check("ld_101", bus.data_ram_in, 8'h22);
    ld(32'h102); check("ld_102", bus.data_ram_in, 8'h33);
    ld(32'h103); check("ld_103", bus.data_ram_in, 8'h44);
    ld(32'h0002_0100); check("ld_alias", bus.data_ram_in, 8'h11);
    st(32'h103, 8'h66); check("rbw_old", bus.data_ram_in, 8'h44);
    ld(32'h103); check("rbw_new", bus.data_ram_in, 8'h66);
    for (int i = 1; i <= 9; i++) begin
      st(32'h0003_0000, 8'(8'hA0 + i));
      check($sformatf("buf_full_%0d", i), bus.io_buffer_full, i >= 6);
      check($sformatf("overflow_%0d", i), io_overflow, i == 9);
    end
    check("tx_head", tx_data, 8'hA1);
    check("tx_valid_full", tx_valid, 1);
    tx_ready = 1'b1;
    st(32'h0003_0000, 8'hB9);
    check("pushpop_full", bus.io_buffer_full, 1);
    drain = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hB9};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_%0d", k), tx_data, drain[k]);
      tick();
    end
    check("drained_valid", tx_valid, 0);
    check("drained_buf_full", bus.io_buffer_full, 0);
    check("overflow_sticky", io_overflow, 1);
    tx_ready = 1'b0;
    st(32'h0001_0000, 8'h77);
    check("io_st_ram_clean", tx_valid, 0);
    rx_valid = 1'b1;
    rx_data = 8'h5A;
`ifdef IO_RX_EN
    rx_exp = 8'h5A;
`else
    rx_exp = 8'h00;
`endif
    ld(32'h0003_0000);
    check("io_ld_data", bus.data_ram_in, rx_exp);
    check("io_ld_rx_pop", rx_pop, rx_exp != 0);
    rx_valid = 1'b0;
    ld(32'h0001_0000);
    check("ram_under_io", bus.data_ram_in, 8'h77);
    check("rx_pop_pulse", rx_pop, 0);
    ld(32'h0003_0008); check("io_other_ld", bus.data_ram_in, 8'h00);
    check("halt_before", sim_halt, 0);
    st(32'h0003_0004, 8'h00); check("halt_set", sim_halt, 1);
    repeat (3) tick();
    check("halt_sticky", sim_halt, 1);
    st(32'h200, 8'h55);
    ld(32'h100); check("pre_freeze", bus.data_ram_in, 8'h11);
    rdy = 1'b0;
    st(32'h200, 8'hAA);
    check("freeze_hold", bus.data_ram_in, 8'h11);
    rdy = 1'b1;
    ld(32'h200); check("freeze_no_write", bus.data_ram_in, 8'h55);
    for (int i = 0; i < 6; i++) st(32'h0003_0000, 8'(8'hC0 + i));
    check("refill_buf_full", bus.io_buffer_full, 1);
    rdy = 1'b0;
    tx_ready = 1'b1;
    tick();
    check("freeze_no_pop", tx_data, 8'hC0);
    #2 rst = 1'b1;
    #1;
    check("async_tx_valid", tx_valid, 0);
    check("async_buf_full", bus.io_buffer_full, 0);
    check("async_halt", sim_halt, 0);
    check("async_overflow", io_overflow, 0);
    check("async_data_in", bus.data_ram_in, 8'h00);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    ld(32'h100); check("ram_survives_rst", bus.data_ram_in, 8'h11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
